// File: rtl/dut_halfband_decim_pkg.sv
// Shared definitions for the halfband decimator slice.
//
// Holds the sample width, the accumulator width, the four non-zero
// coefficient values of the 11-tap halfband kernel and the output
// saturation helper used when the wide sum is brought back to 1s17.
//
// Kernel layout (h[0]..h[10]):
//   C5 0 C3 0 C1 C0 C1 0 C3 0 C5
// The odd taps are exactly zero, which is what makes the halfband
// structure cheap: only three symmetric pairs plus the centre tap multiply.
package dut_halfband_decim_pkg;

    localparam int W     = 18;          // sample / coefficient width (1s17)
    localparam int PREW  = W + 1;       // width of a symmetric pre-add
    localparam int SUMW  = 38;          // accumulator width, no internal overflow
    localparam int FRAC  = 17;          // fractional bits of a 1s17 value
    localparam int TAPS  = 11;

    typedef logic signed [W-1:0] sample_t;

    localparam sample_t C0 = 18'sd65536;     // centre tap h[5] = 0.5
    localparam sample_t C1 = 18'sd40960;     // h[4], h[6]
    localparam sample_t C3 = -18'sd9216;     // h[2], h[8]
    localparam sample_t C5 = 18'sd1024;      // h[0], h[10]

    localparam sample_t SAMPLE_MAX = 18'sh1FFFF;   //  131071
    localparam sample_t SAMPLE_MIN = 18'sh20000;   // -131072

    localparam logic signed [SUMW-1:0] SAT_MAX = SUMW'(SAMPLE_MAX);
    localparam logic signed [SUMW-1:0] SAT_MIN = SUMW'(SAMPLE_MIN);

    // Drop the product fraction with an arithmetic shift (rounds toward
    // -inf) and clamp into the 1s17 range. The step response of this
    // kernel overshoots full scale, so the clamp is genuinely exercised.
    function automatic sample_t saturate(input logic signed [SUMW-1:0] s);
        logic signed [SUMW-1:0] q;
        q = s >>> FRAC;
        if (q > SAT_MAX) begin
            return SAMPLE_MAX;
        end else if (q < SAT_MIN) begin
            return SAMPLE_MIN;
        end else begin
            return W'(q);
        end
    endfunction

endpackage

// File: rtl/dut_halfband_decim_clk_en_gen.sv
// Shared enable generator for the receive chain.
//
// Divides the system clock into single-cycle strobes:
//   sys_clk2_en : 1 in 4 cycles  (input sample rate)
//   sam_clk_en  : 1 in 8 cycles  (decimated output rate)
//   sym_clk_en  : 1 in 32 cycles (symbol rate)
// All strobes are decoded from one free-running counter, so every
// sam_clk_en pulse lands on a sys_clk2_en pulse and every sym_clk_en
// pulse lands on a sam_clk_en pulse. The counter restarts from zero on
// reset, which keeps the phase relationship identical after each release.
//
// Ports:
//   clk          in  system clock, rising edge
//   reset        in  asynchronous, active-low
//   sys_clk2_en  out divide-by-4 strobe
//   sam_clk_en   out divide-by-8 strobe
//   sym_clk_en   out divide-by-32 strobe
module clk_en_gen (
    input  logic clk,
    input  logic reset,
    output logic sys_clk2_en,
    output logic sam_clk_en,
    output logic sym_clk_en
);

    logic [4:0] div_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 5'd1;
        end
    end

    // Strobes fire on the all-ones value of the relevant low bits, so the
    // slower strobes are always subsets of the faster ones.
    assign sys_clk2_en = &div_cnt[1:0];
    assign sam_clk_en  = &div_cnt[2:0];
    assign sym_clk_en  = &div_cnt;

endmodule

// File: rtl/dut_halfband_decim.sv
// 11-tap halfband FIR, decimate-by-2.
//
// Samples enter an 11-deep delay line on sys_clk2_en. On sam_clk_en the
// filter sum of the current (pre-edge) line is truncated, saturated and
// registered on y. Because sam_clk_en is half the input rate, only every
// second filter output is kept.
//
// Ports:
//   clk          in  system clock, rising edge
//   reset        in  asynchronous, active-low; clears delay line and y
//   sys_clk2_en  in  input sample strobe
//   sam_clk_en   in  output strobe (normally coincident with sys_clk2_en)
//   x_in         in  signed 1s17 input sample
//   y            out signed 1s17 filtered, decimated output
module dut_halfband_decim
    import dut_halfband_decim_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    sys_clk2_en,
    input  logic    sam_clk_en,
    input  sample_t x_in,
    output sample_t y
);

    sample_t taps [TAPS];

    logic signed [PREW-1:0] pre_c5;
    logic signed [PREW-1:0] pre_c3;
    logic signed [PREW-1:0] pre_c1;

    logic signed [SUMW-1:0] prod_c5;
    logic signed [SUMW-1:0] prod_c3;
    logic signed [SUMW-1:0] prod_c1;
    logic signed [SUMW-1:0] prod_c0;
    logic signed [SUMW-1:0] filt_sum;

    // Delay line: shifts only on the input strobe, otherwise frozen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                taps[k] <= '0;
            end
        end else if (sys_clk2_en) begin
            taps[0] <= x_in;
            for (int k = 1; k < TAPS; k++) begin
                taps[k] <= taps[k-1];
            end
        end
    end

    // Symmetric pairs share a coefficient, so add them first and multiply
    // once. The odd taps are zero and never reach a multiplier.
    assign pre_c5 = PREW'(taps[0]) + PREW'(taps[10]);
    assign pre_c3 = PREW'(taps[2]) + PREW'(taps[8]);
    assign pre_c1 = PREW'(taps[4]) + PREW'(taps[6]);

    assign prod_c5 = SUMW'(pre_c5)  * SUMW'(C5);
    assign prod_c3 = SUMW'(pre_c3)  * SUMW'(C3);
    assign prod_c1 = SUMW'(pre_c1)  * SUMW'(C1);
    assign prod_c0 = SUMW'(taps[5]) * SUMW'(C0);

    assign filt_sum = prod_c5 + prod_c3 + prod_c1 + prod_c0;

    // Output register samples the sum of the line as it stood before this
    // edge, so a coincident shift never leaks into the same output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y <= '0;
        end else if (sam_clk_en) begin
            y <= saturate(filt_sum);
        end
    end

endmodule

// File: tb/tb_dut_halfband_decim.sv
// Directed testbench for dut_halfband_decim.
//
// Strobes come from the shared clk_en_gen, gated by the bench so it can
// drop either strobe, and OR-ed with force bits used while reset is held.
// An impulse shifted in on the input edge just before an output edge
// reaches the output at tap 0 and walks the even taps; one input later it
// walks the odd taps. Impulse 65536 (0.5) makes each output h[k]/2.
module tb_dut_halfband_decim;
    import dut_halfband_decim_pkg::*;

    logic    clk = 1'b0;
    logic    reset;
    sample_t x_in;
    sample_t y;

    logic gen_sys, gen_sam, gen_sym;
    logic sys_gate, sam_gate, sys_force, sam_force;
    logic sys_clk2_en, sam_clk_en;

    int checkCount = 0;
    int passCount  = 0;

    always #10 clk = ~clk;

    assign sys_clk2_en = (gen_sys & sys_gate) | sys_force;
    assign sam_clk_en  = (gen_sam & sam_gate) | sam_force;

    clk_en_gen u_gen (
        .clk         (clk),
        .reset       (reset),
        .sys_clk2_en (gen_sys),
        .sam_clk_en  (gen_sam),
        .sym_clk_en  (gen_sym)
    );

    dut_halfband_decim u_dut (
        .clk         (clk),
        .reset       (reset),
        .sys_clk2_en (sys_clk2_en),
        .sam_clk_en  (sam_clk_en),
        .x_in        (x_in),
        .y           (y)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Present one sample on the next input strobe; reports whether that
    // edge was also an output edge. y is valid on return.
    task automatic applyStimulus(input int v, output bit was_sam);
        int waited = 0;
        was_sam = 1'b0;
        @(negedge clk);
        while (!gen_sys && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        if (!gen_sys) begin
            checkOutput("sys_strobe_timeout", 0, 1);
        end else begin
            x_in    = W'(v);
            was_sam = gen_sam & sam_gate;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic flushLine();
        bit w;
        repeat (12) applyStimulus(0, w);
    endtask

    // Push zeros until the last push landed on an output edge.
    task automatic alignToSam();
        bit w;
        int guard = 0;
        do begin
            applyStimulus(0, w);
            guard++;
        end while (!w && guard < 4);
        if (!w) checkOutput("align_timeout", 0, 1);
    endtask

    // Full-scale positive step starting on the even phase. Outputs are the
    // running sums of the even taps times 131071/131072, floored; the
    // 139264 partial sum overshoots and must clamp to 131071.
    task automatic runStep(input string tag);
        int step_exp [7] = '{1023, -8192, 32767, 131071, 130047, 131071, 131071};
        bit w;
        alignToSam();
        applyStimulus(131071, w);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(131071, w);
            checkOutput($sformatf("%s_y%0d", tag, i), int'(y), step_exp[i]);
            applyStimulus(131071, w);
        end
    endtask

    initial begin
        int even_exp [7] = '{512, -4608, 20480, 20480, -4608, 512, 0};
        int odd_exp  [6] = '{0, 0, 32768, 0, 0, 0};
        int n_sys, n_sam, n_sym;
        bit w;

        reset     = 1'b0;
        x_in      = '0;
        sys_gate  = 1'b1;
        sam_gate  = 1'b1;
        sys_force = 1'b0;
        sam_force = 1'b0;

        // Reset held: random data and strobes must not disturb y.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            x_in      = W'($urandom);
            sys_force = 1'($urandom);
            sam_force = 1'($urandom);
            @(posedge clk);
            #1;
            checkOutput($sformatf("reset_hold_%0d", i), int'(y), 0);
        end
        @(negedge clk);
        sys_force = 1'b0;
        sam_force = 1'b0;
        x_in      = '0;
        reset     = 1'b1;

        // Generator ratios over 64 consecutive cycles.
        n_sys = 0; n_sam = 0; n_sym = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            n_sys += int'(gen_sys);
            n_sam += int'(gen_sam);
            n_sym += int'(gen_sym);
        end
        checkOutput("gen_sys_count", n_sys, 16);
        checkOutput("gen_sam_count", n_sam, 8);
        checkOutput("gen_sym_count", n_sym, 2);

        // First outputs after release with zero input.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, w);
            if (w) checkOutput("post_release_zero", int'(y), 0);
        end

        // Even-phase impulse.
        flushLine();
        alignToSam();
        applyStimulus(65536, w);
        checkOutput("even_imp_phase", int'(w), 0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, w);
            checkOutput($sformatf("even_imp_y%0d", i), int'(y), even_exp[i]);
            applyStimulus(0, w);
        end

        // Odd-phase impulse: shifted in on an output edge.
        flushLine();
        alignToSam();
        applyStimulus(0, w);
        applyStimulus(65536, w);
        checkOutput("odd_imp_phase", int'(w), 1);
        checkOutput("odd_imp_edge_y", int'(y), 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, w);
            applyStimulus(0, w);
            checkOutput($sformatf("odd_imp_y%0d", i), int'(y), odd_exp[i]);
        end

        // Input strobe dropped for 40 cycles with the impulse parked at
        // tap 2: the line freezes, so every output edge repeats -4608.
        flushLine();
        alignToSam();
        applyStimulus(65536, w);
        applyStimulus(0, w);
        checkOutput("gate_pre_y", int'(y), 512);
        applyStimulus(0, w);
        sys_gate = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bit sam_now;
            @(negedge clk);
            sam_now = gen_sam;
            @(posedge clk);
            #1;
            if (sam_now) checkOutput("sys_gate_hold_y", int'(y), -4608);
        end
        sys_gate = 1'b1;
        applyStimulus(0, w);
        checkOutput("sys_gate_resume_phase", int'(w), 1);
        checkOutput("sys_gate_resume_y0", int'(y), -4608);
        applyStimulus(0, w);
        applyStimulus(0, w);
        checkOutput("sys_gate_resume_y1", int'(y), 20480);

        // Positive full-scale step from an empty line.
        flushLine();
        runStep("step_pos");

        // Output strobe dropped: y holds while the input swings negative.
        sam_gate = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(-131072, w);
            checkOutput("sam_gate_hold_y", int'(y), 131071);
        end
        sam_gate = 1'b1;
        repeat (24) applyStimulus(-131072, w);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(-131072, w);
            if (w) checkOutput("step_neg_settle", int'(y), -131072);
        end

        // Asynchronous reset between clock edges clears y at once.
        #4;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_y", int'(y), 0);
        @(negedge clk);
        reset = 1'b1;

        // History discarded: the step must repeat the power-up response.
        runStep("step_after_reset");

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
